traffic_phase_scheduler: RTL and testbench
==========================================

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green duration in cycles; legal range 1 to 255.
REQ-002 Parameter GREEN_MAX, default 8: green duration in cycles after which a waiting cross road forces a change; GREEN_MAX >= GREEN_MIN, at most 255.
REQ-003 Parameter YELLOW_CYC, default 2: yellow duration in cycles; at least 1.
REQ-004 Parameter ALLRED_CYC, default 1: all-red clearance duration in cycles; at least 1.
REQ-005 Parameter WALK_CYC, default 3: pedestrian walk duration in cycles; at least 1.
REQ-006 clk  in  1  rising-edge clock, single clock domain.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 ta  in  1  road A traffic-present sensor.
REQ-009 tb  in  1  road B traffic-present sensor.
REQ-010 ped_req  in  1  pedestrian request; a single-cycle pulse is sufficient.
REQ-011 la  out  2  road A light: 00 green, 01 yellow, 10 red.
REQ-012 lb  out  2  road B light, with the same encoding as la.
REQ-013 walk  out  1  pedestrian walk indication.
REQ-014 phase  out  3  current phase encoding, taken from the package enum.
REQ-015 phase_start  out  1  one-cycle pulse in the first cycle of every new phase.

Function
REQ-016 Phases shall be A_GRN, A_YEL, RED_AB, B_GRN, B_YEL, RED_BA and WALK; all outputs shall be registered and decoded from the phase.
REQ-017 Light mapping shall be:
- A_GRN: la=00, lb=10.
- A_YEL: la=01, lb=10.
- B_GRN: la=10, lb=00.
- B_YEL: la=10, lb=01.
- RED_AB, RED_BA and WALK: both la and lb red.
- walk=1 only in WALK.
REQ-018 The dwell counter shall clear to 0 on phase entry and increment once per cycle. It shall saturate at GREEN_MAX-1 in the green phases.
REQ-019 A_GRN shall exit to A_YEL at the clock edge where all of the following hold:
- tb is 1;
- count >= GREEN_MIN-1;
- ta is 0, or count == GREEN_MAX-1.
REQ-020 B_GRN shall exit using the same rule as REQ-019 with ta and tb swapped.
REQ-021 A green phase shall rest indefinitely when the cross road has no traffic, regardless of the dwell counter.
REQ-022 Each yellow phase shall last exactly YELLOW_CYC cycles and then enter its all-red phase.
REQ-023 Each all-red phase shall last exactly ALLRED_CYC cycles.
REQ-024 At the end of an all-red phase, the block shall enter WALK if a pedestrian request is pending; otherwise it shall enter the opposite road's green.
REQ-025 WALK shall last WALK_CYC cycles and then enter the green that follows the interrupted all-red: B_GRN after RED_AB, A_GRN after RED_BA.
REQ-026 ped_req shall set a pending flag, which clears on entry to WALK.
REQ-027 If ped_req is asserted in the same cycle as WALK entry, the pending flag shall remain set.
REQ-028 phase_start shall be 1 in the first cycle of each phase and 0 while a green phase rests.

Reset
REQ-029 While reset_n=0, the block shall immediately hold the following values, independent of clk:
- phase=A_GRN, counter=0, pending=0;
- la=00, lb=10;
- walk=0, phase_start=0.
REQ-030 Assertion of reset_n mid-phase shall abandon that phase with no completion of its yellow or all-red.
REQ-031 The first cycle after reset_n is released shall count as dwell cycle 0 of A_GRN.

Configuration
REQ-032 Macro TRAFFIC_PED_WALK_EN shall compile the pedestrian feature in.
REQ-033 With TRAFFIC_PED_WALK_EN defined, WALK, the pending flag and the ped_req handling shall exist as specified above.
REQ-034 Without TRAFFIC_PED_WALK_EN:
- ped_req shall be ignored and walk tied to 0;
- WALK shall be unreachable;
- all ports shall remain present.

Structure
REQ-035 Package traffic_pkg shall hold the light constants GREEN, YELLOW and RED and the 3-bit phase_t enum.
REQ-036 Sub-module phase_timer shall contain the dwell counter, with inputs clear and sat and output count.
REQ-037 The scheduler FSM and the output decode shall reside in traffic_phase_scheduler.

Verification
All scenarios use GREEN_MIN=4, GREEN_MAX=8, YELLOW_CYC=2, ALLRED_CYC=1 and WALK_CYC=3, with TRAFFIC_PED_WALK_EN defined unless stated otherwise.
REQ-038 ta=0 and tb=0 for 50 cycles after reset: la=00 and lb=10 throughout, and phase_start=0 throughout.
REQ-039 ta=0 and tb=1 from release:
- la=00 for cycles 0-3;
- la=01 for cycles 4-5;
- both red in cycle 6;
- lb=00 from cycle 7.
REQ-040 ta=1 and tb=1 held: each green lasts 8 cycles, and the A_GRN-to-A_GRN period is 22 cycles.
REQ-041 One-cycle ped_req during B_GRN with ta=1:
- after RED_BA, walk=1 and both lights red for 3 cycles;
- then A_GRN follows;
- a second ped_req asserted in the WALK entry cycle produces another WALK at the next all-red.
REQ-042 reset_n pulsed low in the second yellow cycle: la=00, lb=10 and walk=0 during reset, and count=0 after release.
REQ-043 Build without TRAFFIC_PED_WALK_EN, with ped_req held at 1: walk stays 0, phase never equals WALK, and timing matches REQ-040.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light codes, phase enum and light decode helpers for the traffic
// phase scheduler.
package traffic_pkg;

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;

   typedef enum logic [2:0] {
      A_GRN  = 3'd0,
      A_YEL  = 3'd1,
      RED_AB = 3'd2,
      B_GRN  = 3'd3,
      B_YEL  = 3'd4,
      RED_BA = 3'd5,
      WALK   = 3'd6
   } phase_t;

   function automatic logic [1:0] light_a(input phase_t p);
      case (p)
         A_GRN:   return GREEN;
         A_YEL:   return YELLOW;
         default: return RED;
      endcase
   endfunction

   function automatic logic [1:0] light_b(input phase_t p);
      case (p)
         B_GRN:   return GREEN;
         B_YEL:   return YELLOW;
         default: return RED;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell counter: clears on phase entry, counts once per cycle and optionally
// holds at SAT_VAL (used while a green phase rests).
module phase_timer #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   SAT_VAL = '1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         sat,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // Next count: clear wins, then saturation hold, else increment.
   always_comb begin
      count_d = count_q + 1'b1;
      if (clear) begin
         count_d = '0;
      end else if (sat && (count_q == SAT_VAL)) begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light phase scheduler with optional pedestrian walk phase.
// Define TRAFFIC_PED_WALK_EN to build the pedestrian feature (WALK phase,
// pending request flag); without it ped_req is ignored and walk is 0.
// All outputs are registered copies of the decode of the next phase.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN  = 4,
   parameter int GREEN_MAX  = 8,
   parameter int YELLOW_CYC = 2,
   parameter int ALLRED_CYC = 1,
   parameter int WALK_CYC   = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ta,
   input  logic       tb,
   input  logic       ped_req,
   output logic [1:0] la,
   output logic [1:0] lb,
   output logic       walk,
   output phase_t     phase,
   output logic       phase_start
);

   // Counter only has to reach the longest phase length minus one.
   localparam int M1   = (GREEN_MAX > YELLOW_CYC) ? GREEN_MAX : YELLOW_CYC;
   localparam int M2   = (ALLRED_CYC > WALK_CYC) ? ALLRED_CYC : WALK_CYC;
   localparam int MAXD = (M1 > M2) ? M1 : M2;
   localparam int CW   = (MAXD < 2) ? 1 : $clog2(MAXD);

   localparam logic [CW-1:0] G_MIN_C  = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] G_MAX_C  = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] YEL_END  = CW'(YELLOW_CYC - 1);
   localparam logic [CW-1:0] RED_END  = CW'(ALLRED_CYC - 1);
   localparam logic [CW-1:0] WALK_END = CW'(WALK_CYC - 1);

   phase_t          phase_q, phase_d;
   logic [1:0]      la_q, lb_q;
   logic            start_q;
   logic [CW-1:0]   count;
   logic            phase_chg;
   logic            in_green;
   logic            ped_go;     // pending request diverts all-red into WALK
   logic            walk_to_b;  // WALK returns to B_GRN (entered from RED_AB)

   assign phase_chg = (phase_d != phase_q);
   assign in_green  = (phase_q == A_GRN) || (phase_q == B_GRN);

   phase_timer #(
      .W       (CW),
      .SAT_VAL (G_MAX_C)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (phase_chg),
      .sat     (in_green),
      .count   (count)
   );

   // Next-phase selection from dwell count, sensors and pending walk.
   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         A_GRN:  if (tb && (count >= G_MIN_C) && (!ta || (count == G_MAX_C))) phase_d = A_YEL;
         A_YEL:  if (count == YEL_END) phase_d = RED_AB;
         RED_AB: if (count == RED_END) phase_d = ped_go ? WALK : B_GRN;
         B_GRN:  if (ta && (count >= G_MIN_C) && (!tb || (count == G_MAX_C))) phase_d = B_YEL;
         B_YEL:  if (count == YEL_END) phase_d = RED_BA;
         RED_BA: if (count == RED_END) phase_d = ped_go ? WALK : A_GRN;
         WALK:   if (count == WALK_END) phase_d = walk_to_b ? B_GRN : A_GRN;
         default: phase_d = A_GRN;
      endcase
   end

   // Phase register and registered output decode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= A_GRN;
         la_q    <= GREEN;
         lb_q    <= RED;
         start_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         la_q    <= light_a(phase_d);
         lb_q    <= light_b(phase_d);
         start_q <= phase_chg;
      end
   end

`ifdef TRAFFIC_PED_WALK_EN
   logic pend_q, pend_d;
   logic ret_b_q, ret_b_d;
   logic walk_q;
   logic walk_entry;

   assign walk_entry = (phase_d == WALK) && (phase_q != WALK);

   // A new request in the entry cycle survives the clear, so set wins.
   always_comb begin
      pend_d  = ped_req | (pend_q & ~walk_entry);
      ret_b_d = ret_b_q;
      if (walk_entry) ret_b_d = (phase_q == RED_AB);
   end

   // Pedestrian state and walk output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q  <= 1'b0;
         ret_b_q <= 1'b0;
         walk_q  <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         ret_b_q <= ret_b_d;
         walk_q  <= (phase_d == WALK);
      end
   end

   assign ped_go    = pend_q;
   assign walk_to_b = ret_b_q;
   assign walk      = walk_q;
`else
   logic unused_ped;
   assign unused_ped = ped_req;
   assign ped_go     = 1'b0;
   assign walk_to_b  = 1'b0;
   assign walk       = 1'b0;
`endif

   assign la          = la_q;
   assign lb          = lb_q;
   assign phase       = phase_q;
   assign phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed table, corner
// sequences and randomized traffic against a phase/age reference model.
module tb_traffic_phase_scheduler;
   import traffic_pkg::*;

   localparam int GMIN  = 4;
   localparam int GMAX  = 8;
   localparam int YEL   = 2;
   localparam int ARED  = 1;
   localparam int WALKC = 3;
`ifdef TRAFFIC_PED_WALK_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       ta = 1'b0, tb = 1'b0, ped_req = 1'b0;
   logic [1:0] la, lb;
   logic       walk, phase_start;
   phase_t     phase;

   int nvec = 0;
   int nfail = 0;

   // Reference model state: phase, unsaturated age in phase, pending, return.
   phase_t m_ph;
   int     m_age;
   bit     m_pend, m_ret_b, m_start;

   always #5 clk = ~clk;

   traffic_phase_scheduler #(
      .GREEN_MIN (GMIN), .GREEN_MAX (GMAX), .YELLOW_CYC (YEL),
      .ALLRED_CYC (ARED), .WALK_CYC (WALKC)
   ) dut (
      .clk (clk), .reset_n (reset_n), .ta (ta), .tb (tb), .ped_req (ped_req),
      .la (la), .lb (lb), .walk (walk), .phase (phase), .phase_start (phase_start)
   );

   typedef struct {
      logic       ta, tb;
      logic [1:0] la, lb;
      phase_t     ph;
      logic       ps;
   } vec_t;
   vec_t tbl [11];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_la(input phase_t p);
      if (p == A_GRN) return 2'b00;
      if (p == A_YEL) return 2'b01;
      return 2'b10;
   endfunction

   function automatic logic [1:0] exp_lb(input phase_t p);
      if (p == B_GRN) return 2'b00;
      if (p == B_YEL) return 2'b01;
      return 2'b10;
   endfunction

   task automatic model_reset();
      m_ph = A_GRN; m_age = 0; m_pend = 0; m_ret_b = 0; m_start = 0;
   endtask

   // Advance the model across one clock edge using the current inputs.
   task automatic model_step();
      phase_t nx;
      bit     leave;
      nx = m_ph;
      case (m_ph)
         A_GRN:         leave = tb && (m_age >= GMIN-1) && (!ta || m_age >= GMAX-1);
         B_GRN:         leave = ta && (m_age >= GMIN-1) && (!tb || m_age >= GMAX-1);
         A_YEL, B_YEL:  leave = (m_age == YEL-1);
         RED_AB, RED_BA: leave = (m_age == ARED-1);
         default:       leave = (m_age == WALKC-1);
      endcase
      if (leave) begin
         case (m_ph)
            A_GRN:   nx = A_YEL;
            A_YEL:   nx = RED_AB;
            B_GRN:   nx = B_YEL;
            B_YEL:   nx = RED_BA;
            RED_AB:  nx = (PED_EN && m_pend) ? WALK : B_GRN;
            RED_BA:  nx = (PED_EN && m_pend) ? WALK : A_GRN;
            default: nx = m_ret_b ? B_GRN : A_GRN;
         endcase
      end
      if (nx == WALK && m_ph != WALK) begin
         m_ret_b = (m_ph == RED_AB);
         m_pend  = ped_req;
      end else begin
         m_pend = m_pend | (PED_EN && ped_req);
      end
      m_start = leave;
      m_age   = leave ? 0 : m_age + 1;
      m_ph    = nx;
   endtask

   // Sample at the falling edge and compare every output with the model.
   task automatic sample(input string nm);
      @(negedge clk);
      check(nm, {23'd0, la, lb, walk, phase, phase_start},
            {23'd0, exp_la(m_ph), exp_lb(m_ph), (m_ph == WALK), m_ph, m_start});
   endtask

   task automatic adv();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Async reset pulse: outputs must settle before any clock edge.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1 check("reset_outputs", {26'd0, la, lb, walk, phase_start},
               {26'd0, GREEN, RED, 1'b0, 1'b0});
      check("reset_phase", {29'd0, phase}, {29'd0, A_GRN});
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int first_a, second_a, a_grn_n, b_grn_n, walk_n;

      tbl[0]  = '{1'b0, 1'b1, GREEN,  RED,   A_GRN,  1'b0};
      tbl[1]  = '{1'b0, 1'b1, GREEN,  RED,   A_GRN,  1'b0};
      tbl[2]  = '{1'b0, 1'b1, GREEN,  RED,   A_GRN,  1'b0};
      tbl[3]  = '{1'b0, 1'b1, GREEN,  RED,   A_GRN,  1'b0};
      tbl[4]  = '{1'b0, 1'b1, YELLOW, RED,   A_YEL,  1'b1};
      tbl[5]  = '{1'b0, 1'b1, YELLOW, RED,   A_YEL,  1'b0};
      tbl[6]  = '{1'b0, 1'b1, RED,    RED,   RED_AB, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, RED,    GREEN, B_GRN,  1'b1};
      tbl[8]  = '{1'b0, 1'b1, RED,    GREEN, B_GRN,  1'b0};
      tbl[9]  = '{1'b0, 1'b1, RED,    GREEN, B_GRN,  1'b0};
      tbl[10] = '{1'b0, 1'b1, RED,    GREEN, B_GRN,  1'b0};

      // No traffic anywhere: A green rests, no phase_start pulses.
      model_reset();
      do_reset();
      ta = 0; tb = 0;
      for (int c = 0; c < 50; c++) begin
         sample($sformatf("idle_model c%0d", c));
         check($sformatf("idle_lights c%0d", c), {27'd0, la, lb, phase_start},
               {27'd0, GREEN, RED, 1'b0});
         adv();
      end

      // Table: cross traffic only on B from release.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         ta = tbl[i].ta; tb = tbl[i].tb; ped_req = 1'b0;
         sample($sformatf("tbl_model c%0d", i));
         check($sformatf("tbl c%0d", i), {24'd0, la, lb, phase, phase_start},
               {24'd0, tbl[i].la, tbl[i].lb, tbl[i].ph, tbl[i].ps});
         adv();
      end

      // Both roads busy: 8-cycle greens, 22-cycle period; ped held if no walk.
      do_reset();
      ta = 1; tb = 1; ped_req = !PED_EN;
      first_a = -1; second_a = -1; a_grn_n = 0; b_grn_n = 0; walk_n = 0;
      for (int c = 0; c < 50; c++) begin
         sample($sformatf("busy_model c%0d", c));
         if (phase_start && phase == A_GRN) begin
            if (first_a < 0) first_a = c;
            else if (second_a < 0) second_a = c;
         end
         if (c < 22 && la == GREEN) a_grn_n++;
         if (c < 22 && lb == GREEN) b_grn_n++;
         if (walk || phase == WALK) walk_n++;
         adv();
      end
      ped_req = 0;
      check("period_first",  first_a,  22);
      check("period_second", second_a, 44);
      check("a_green_len",   a_grn_n,  8);
      check("b_green_len",   b_grn_n,  8);
      check("no_walk_busy",  walk_n,   0);

`ifdef TRAFFIC_PED_WALK_EN
      // Pedestrian pulse in B_GRN, then a second one in the WALK entry cycle.
      do_reset();
      ta = 1; tb = 1;
      for (int c = 0; c < 42; c++) begin
         ped_req = (c == 12) || (c == 22);
         sample($sformatf("ped_model c%0d", c));
         if (c >= 22 && c <= 24)
            check($sformatf("walk1 c%0d", c), {27'd0, walk, la, lb}, {27'd0, 1'b1, RED, RED});
         if (c == 25) check("after_walk1", {29'd0, walk, la}, {29'd0, 1'b0, GREEN});
         if (c == 36) check("walk2", {29'd0, walk, lb}, {29'd0, 1'b1, RED});
         if (c == 39) check("after_walk2", {29'd0, walk, lb}, {29'd0, 1'b0, GREEN});
         adv();
      end
      ped_req = 0;
`endif

      // Reset in the second yellow cycle, then timing restarts from count 0.
      do_reset();
      ta = 1; tb = 1;
      for (int c = 0; c < 9; c++) begin
         sample($sformatf("pre_rst c%0d", c));
         adv();
      end
      sample("yel2");
      check("yel2_light", {30'd0, la}, {30'd0, YELLOW});
      do_reset();
      ta = 0; tb = 1;
      first_a = -1;
      for (int c = 0; c < 8; c++) begin
         sample($sformatf("post_rst c%0d", c));
         if (first_a < 0 && la == YELLOW) first_a = c;
         adv();
      end
      check("post_rst_yellow_at", first_a, 4);

      // Randomized traffic, pedestrian requests and occasional resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) ta = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) tb = $urandom_range(0, 1);
         ped_req = ($urandom_range(0, 15) == 0);
         sample($sformatf("rand c%0d", c));
         if ($urandom_range(0, 499) == 0) do_reset();
         else adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
